// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI slave front end, deserialises 10-bit command words and serialises RAM read bytes onto MISO
module spi_slave_if #(
    parameter int ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SS_n,
    input  logic                 MOSI,
    output logic                 MISO,
    output logic [ADDR_SIZE+1:0] rx_data,
    output logic                 rx_valid,
    input  logic [ADDR_SIZE-1:0] tx_data,
    input  logic                 tx_valid
);
    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;
    localparam int TW = $clog2(ADDR_SIZE + 1);
    localparam logic [TW-1:0] LAST = TW'(ADDR_SIZE);
    state_t state, next;
    logic [3:0] cnt;
    logic [TW-1:0] tx_cnt;
    logic [ADDR_SIZE-1:0] tx_sr;
    logic rd_addr_seen, tx_busy, tx_done, shifting, rx_last, waiting;
    assign shifting = !SS_n && (state inside {WRITE, READ_ADD, READ_DATA}) && cnt != 4'd10;
    assign rx_last  = shifting && cnt == 4'd9;
    assign waiting  = !SS_n && state == READ_DATA && cnt == 4'd10 && !tx_busy && !tx_done;
    always_comb begin
        next = state == IDLE ? (SS_n ? IDLE : CHK_CMD) :
               SS_n ? IDLE :
               state == CHK_CMD ? (!MOSI ? WRITE : rd_addr_seen ? READ_DATA : READ_ADD) :
               state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= next;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            MISO         <= 1'b0;
            cnt          <= '0;
            rd_addr_seen <= 1'b0;
            tx_sr        <= '0;
            tx_cnt       <= '0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            rx_valid <= rx_last;
            MISO     <= tx_busy && !SS_n && tx_cnt != LAST && tx_sr[ADDR_SIZE-1];
            if (shifting) begin
                rx_data <= {rx_data[ADDR_SIZE:0], MOSI};
                cnt     <= cnt + 4'd1;
            end else if (SS_n) cnt <= '0;
            if (rx_last && state == READ_ADD) rd_addr_seen <= 1'b1;
            if (waiting && tx_valid) begin
                tx_sr   <= tx_data;
                tx_cnt  <= '0;
                tx_busy <= 1'b1;
            end else if (tx_busy && !SS_n) begin
                tx_sr  <= tx_sr << 1;
                tx_cnt <= tx_cnt + 1'b1;
                if (tx_cnt == LAST) begin
                    tx_busy      <= 1'b0;
                    tx_done      <= 1'b1;
                    rd_addr_seen <= 1'b0;
                end
            end
            if (SS_n) begin
                tx_busy <= 1'b0;
                tx_done <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_if.sv
// tb_spi_slave_if: table-driven frame checks plus abort and async-reset sequences
module tb_spi_slave_if;
    logic clk = 1'b0, rst_n = 1'b0, SS_n = 1'b1, MOSI = 1'b0, tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic MISO, rx_valid;
    logic [9:0] rx_data;
    int tests = 0, fails = 0;

    spi_slave_if #(.ADDR_SIZE(8)) dut (
        .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic [9:0] w;
        logic       give;
        logic [7:0] tx;
        logic [9:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Frame: SS_n low, select bit, 10 word bits, optional tx_valid in the wait phase, SS_n high at index 27.
    task automatic run_frame(input string tag, input logic sel, input logic [9:0] w, input logic give,
                             input logic [7:0] tx, input logic [9:0] exp_rx, input logic [7:0] exp_miso);
        int pulses = 0, first = -1, stray = 0;
        logic [9:0] got = '0;
        logic [7:0] mb = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rx_valid) begin
                pulses++;
                if (first < 0) begin
                    first = c;
                    got = rx_data;
                end
            end
            if (c >= 16 && c <= 23) mb[23-c] = MISO;
            else if (MISO) stray++;
            SS_n = c >= 27;
            MOSI = c == 1 ? sel : (c >= 2 && c <= 11) ? w[11-c] : 1'b0;
            tx_valid = give && c == 14;
            tx_data = tx;
        end
        @(negedge clk);
        check({tag, " rx_data"}, 32'(got), 32'(exp_rx));
        check({tag, " pulses"}, 32'(pulses), 32'd1);
        check({tag, " pulse_cycle"}, 32'(first), 32'd12);
        check({tag, " miso_byte"}, 32'(mb), 32'(exp_miso));
        check({tag, " miso_stray"}, 32'(stray), 32'd0);
        check({tag, " rx_hold"}, 32'(rx_data), 32'(exp_rx));
    endtask

    initial begin
        int pulses;
        vecs[0] = '{1'b0, 10'h005, 1'b0, 8'h00, 10'h005, 8'h00};
        vecs[1] = '{1'b0, 10'h1A5, 1'b0, 8'h00, 10'h1A5, 8'h00};
        vecs[2] = '{1'b1, 10'h205, 1'b1, 8'hFF, 10'h205, 8'h00};
        vecs[3] = '{1'b1, 10'h3C3, 1'b1, 8'hA5, 10'h3C3, 8'hA5};
        vecs[4] = '{1'b1, 10'h20F, 1'b1, 8'h5A, 10'h20F, 8'h00};
        vecs[5] = '{1'b1, 10'h300, 1'b1, 8'h3C, 10'h300, 8'h3C};
        vecs[6] = '{1'b0, 10'h0FF, 1'b1, 8'hFF, 10'h0FF, 8'h00};
        vecs[7] = '{1'b1, 10'h2AA, 1'b0, 8'h00, 10'h2AA, 8'h00};
        vecs[8] = '{1'b0, 10'h155, 1'b0, 8'h00, 10'h155, 8'h00};
        vecs[9] = '{1'b1, 10'h3FF, 1'b1, 8'h81, 10'h3FF, 8'h81};

        repeat (2) @(negedge clk);
        check("reset MISO", 32'(MISO), 32'd0);
        check("reset rx_valid", 32'(rx_valid), 32'd0);
        check("reset rx_data", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].sel, vecs[i].w, vecs[i].give,
                      vecs[i].tx, vecs[i].exp_rx, vecs[i].exp_miso);

        pulses = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            if (rx_valid) pulses++;
            SS_n = c >= 7;
            MOSI = c >= 2 && c <= 6;
        end
        check("abort pulses", 32'(pulses), 32'd0);
        run_frame("post_abort", 1'b0, 10'h0AB, 1'b0, 8'h00, 10'h0AB, 8'h00);

        run_frame("rst_addr", 1'b1, 10'h2AA, 1'b0, 8'h00, 10'h2AA, 8'h00);
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            SS_n = 1'b0;
            MOSI = c == 1 || (c >= 2 && c <= 11);
            tx_valid = c == 12;
            tx_data = 8'hFF;
        end
        @(posedge clk);
        #2;
        check("pre_reset MISO", 32'(MISO), 32'd1);
        check("pre_reset rx_data", 32'(rx_data), 32'h3FF);
        rst_n = 1'b0;
        #1;
        check("async MISO", 32'(MISO), 32'd0);
        check("async rx_valid", 32'(rx_valid), 32'd0);
        check("async rx_data", 32'(rx_data), 32'd0);
        @(negedge clk);
        SS_n = 1'b1;
        tx_valid = 1'b0;
        MOSI = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        run_frame("post_reset", 1'b1, 10'h211, 1'b1, 8'hC3, 10'h211, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
